// File: rtl/lfsr_controller.sv
// Memory-mapped sequencer for a 32-bit Galois LFSR: hold / free-run / step-per-read, seeding, step count.
// Optional threshold interrupt (THRESH register and oIRQ) is built when LFSR_IRQ_EN is defined.
module lfsr_controller #(
   parameter logic [31:0] BASE = 32'hFF200400,
   parameter logic [31:0] TAPS = 32'h80200003
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        wReadEnable,
   input  logic        wWriteEnable,
   input  logic [3:0]  wByteEnable,
   input  logic [31:0] wAddress,
   input  logic [31:0] wWriteData,
   output logic [31:0] wReadData
`ifdef LFSR_IRQ_EN
   ,
   output logic        oIRQ
`endif
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFree   = 2'd1,
      StOnRead = 2'd2
   } state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [1:0]  r_ctrl;
   logic [31:0] r_lfsr;
   logic [31:0] r_count;

   logic        w_hit_ctrl;
   logic        w_hit_seed;
   logic        w_hit_data;
   logic        w_hit_count;
   logic        w_ctrl_wr;
   logic        w_seed_wr;
   logic        w_data_rd;
   logic        w_step;
   logic [31:0] w_lfsr_step;
   logic [31:0] w_seed_merged;
   logic [31:0] w_seed_value;
   logic        w_read_hit;
   logic [31:0] w_read_mux;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return merged;
   endfunction

   assign w_hit_ctrl  = (wAddress == BASE);
   assign w_hit_seed  = (wAddress == BASE + 32'h4);
   assign w_hit_data  = (wAddress == BASE + 32'h8);
   assign w_hit_count = (wAddress == BASE + 32'hC);

   // Only lane 0 carries CTRL bits, so a CTRL write without lane 0 changes nothing.
   assign w_ctrl_wr = wWriteEnable && w_hit_ctrl && wByteEnable[0];
   assign w_seed_wr = wWriteEnable && w_hit_seed && (wByteEnable != 4'b0000);
   assign w_data_rd = wReadEnable && w_hit_data;

   assign w_lfsr_step   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);
   assign w_seed_merged = byte_merge(r_lfsr, wWriteData, wByteEnable);
   assign w_seed_value  = (w_seed_merged == 32'h0) ? 32'h1 : w_seed_merged;

   // FSM state register
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: follows the CTRL value being written on this edge
   always_comb begin
      w_state_next = r_state;
      if (w_ctrl_wr) begin
         if (!wWriteData[0]) begin
            w_state_next = StIdle;
         end else if (wWriteData[1]) begin
            w_state_next = StOnRead;
         end else begin
            w_state_next = StFree;
         end
      end
   end

   // FSM output: step decision uses the mode in force before this edge
   always_comb begin
      w_step = 1'b0;
      case (r_state)
         StFree:   w_step = 1'b1;
         StOnRead: w_step = w_data_rd;
         default:  w_step = 1'b0;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_ctrl  <= 2'b00;
         r_lfsr  <= 32'h1;
         r_count <= 32'h0;
      end else begin
         if (w_ctrl_wr) begin
            r_ctrl <= wWriteData[1:0];
         end
         if (w_seed_wr) begin
            r_lfsr  <= w_seed_value;
            r_count <= 32'h0;
         end else if (w_step) begin
            r_lfsr  <= w_lfsr_step;
            r_count <= r_count + 32'h1;
         end
      end
   end

`ifdef LFSR_IRQ_EN
   logic [31:0] r_thresh;
   logic        r_irq;
   logic        w_hit_thresh;
   logic        w_irq_set;
   logic        w_irq_clr;

   assign w_hit_thresh = (wAddress == BASE + 32'h10);
   assign w_irq_set    = w_step && !w_seed_wr && (r_thresh != 32'h0)
                         && ((r_count + 32'h1) == r_thresh);
   assign w_irq_clr    = w_ctrl_wr && wWriteData[2];

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_thresh <= 32'h0;
         r_irq    <= 1'b0;
      end else begin
         if (wWriteEnable && w_hit_thresh) begin
            r_thresh <= byte_merge(r_thresh, wWriteData, wByteEnable);
         end
         if (w_irq_clr) begin
            r_irq <= 1'b0;
         end else if (w_irq_set) begin
            r_irq <= 1'b1;
         end
      end
   end

   assign oIRQ = r_irq;
`endif

   always_comb begin
      w_read_hit = 1'b0;
      w_read_mux = 32'h0;
      if (wReadEnable) begin
         if (w_hit_ctrl) begin
            w_read_hit = 1'b1;
            w_read_mux = {30'h0, r_ctrl};
         end else if (w_hit_seed || w_hit_data) begin
            w_read_hit = 1'b1;
            w_read_mux = r_lfsr;
         end else if (w_hit_count) begin
            w_read_hit = 1'b1;
            w_read_mux = r_count;
         end
`ifdef LFSR_IRQ_EN
         else if (w_hit_thresh) begin
            w_read_hit = 1'b1;
            w_read_mux = r_thresh;
         end
`endif
      end
   end

   assign wReadData = w_read_hit ? w_read_mux : 32'hzzzzzzzz;

endmodule

// File: doc/lfsr_controller.md
# lfsr_controller

Memory-mapped sequencer for a 32-bit Galois LFSR on the processor IO bus. It owns the LFSR state and decides when the state advances: held, free-running every clock, or exactly one step per software read. It also handles seeding, including byte-masked seed writes, and keeps a step counter. It sits on the IO bus beside the other peripherals, clocked by the CPU clock, and drives the bus only when its own addresses are read.

## Interface
- BASE, default 32'hFF200400: byte address of register 0; the block decodes BASE+0x00 to BASE+0x10.
- TAPS, default 32'h80200003: Galois feedback mask (x^32+x^22+x^2+x+1).
- iCLK  in  1  sole clock; all state updates on the rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- wReadEnable  in  1  bus read strobe.
- wWriteEnable  in  1  bus write strobe.
- wByteEnable  in  4  write byte lanes; bit i enables bits 8i+7:8i.
- wAddress  in  32  bus byte address.
- wWriteData  in  32  write data.
- wReadData  out  32  read data; 32'hzzzzzzzz unless a read hits a decoded address.
- oIRQ  out  1  threshold interrupt; present only with LFSR_IRQ_EN.

## Operation
- Registers:
  - CTRL @+0x00 R/W: bit0 RUN, bit1 STEP_ON_READ. Bit2 IRQ_CLR is write-only and reads 0. Other bits read 0.
  - SEED @+0x04 W: load the state. Reads return the current state.
  - DATA @+0x08 R: current state. Writes are ignored.
  - COUNT @+0x0C R: steps since the last seed. 32-bit, wraps 0xFFFFFFFF->0. Writes are ignored.
  - THRESH @+0x10 R/W: only with the macro.
- Step: s <= {1'b0, s[31:1]} ^ (s[0] ? TAPS : 0). COUNT <= COUNT+1 on every step.
- FSM is a registered 2-bit state, derived from CTRL on the edge that writes it:
  - IDLE (RUN=0): state is held.
  - FREE (RUN=1, STEP_ON_READ=0): one step per clock.
  - ONREAD (RUN=1, STEP_ON_READ=1): one step on the clock edge that ends a bus cycle with wReadEnable=1 and wAddress=BASE+0x08.
- Seed write: the new state is the current state with the enabled bytes replaced by wWriteData. If the merged result is 0, it is forced to 32'h00000001 to prevent lock-up. COUNT is cleared to 0.
- Simultaneous events:
  - Seed write and step in the same cycle: the seed wins, no step occurs, and COUNT=0.
  - CTRL write and step in the same cycle: the step is decided by the old mode.
- Byte enables apply to CTRL and THRESH writes. A write with wByteEnable=0000 has no effect, including no seed load.
- Reset (asynchronous, any time): state=32'h00000001, COUNT=0, CTRL=0, FSM=IDLE, THRESH=0, oIRQ=0. A pending ONREAD step is discarded.

## Timing
- Reads are combinational. wReadData is valid in the same cycle as wReadEnable and shows the pre-edge state.
- A DATA read in ONREAD mode returns value N. The next DATA read returns step(N). There is no read-ahead.
- Writes take effect at the rising edge that ends the write cycle. A mode change first affects the following edge.
- FREE mode: k edges after RUN is set, COUNT has advanced by k.

## Configuration
- Macro: LFSR_IRQ_EN.
- Defined:
  - THRESH register exists.
  - oIRQ is set (sticky) on the edge where COUNT becomes equal to THRESH, provided THRESH≠0.
  - oIRQ is cleared by a CTRL write with bit2=1 (byte lane 0 enabled). If set and clear occur together, clear wins.
  - A seed write does not clear oIRQ.
- Undefined:
  - No THRESH register; BASE+0x10 is undecoded and reads hi-Z.
  - No oIRQ port and no IRQ logic.

## Test plan
- Reset, then read DATA -> 0x00000001. COUNT -> 0. Unmapped read BASE+0x14 -> hi-Z.
- Write SEED=0x00000001 (BE=1111), CTRL=0x3. Read DATA -> 0x00000001. Read DATA -> 0x80200003. COUNT -> 2. A SEED read in between does not step.
- Write SEED=0x00000000 -> DATA 0x00000001 and COUNT 0. From state 0x00000001, write SEED=0x12345678 with BE=1100 -> DATA 0x12340001.
- CTRL=0x1 for 3 edges, then CTRL=0x0 -> COUNT=3 and DATA=step³(seed). In the same edge as a FREE step, write SEED=0xCAFEF00D -> DATA 0xCAFEF00D, COUNT 0.
- With LFSR_IRQ_EN: THRESH=4, seed, then FREE -> oIRQ rises on the 4th step edge and stays high after CTRL=0. A CTRL write of 0x4 clears it.
- Assert iRST_n low mid-FREE, asynchronously between edges -> outputs return to reset values immediately. After release, DATA=0x00000001 and nothing steps until CTRL is written.
